oit_bin_to_bcd: RTL and testbench

//   Sequential double-dabble converter: unsigned binary word -> packed BCD digits.

---
 rtl/oit_bin_to_bcd_if.sv | 16 +
 rtl/oit_bin_to_bcd.sv | 93 +++++++++
 tb/tb_oit_bin_to_bcd.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/oit_bin_to_bcd_if.sv
// Start/busy/done handshake and result bus between a client and the binary-to-BCD converter.
// master drives the request; slave (the converter) returns status and the held result.
interface oit_bin_to_bcd_if #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
);
  logic                  start;
  logic [WIDTH-1:0]      in;
  logic                  busy;
  logic                  done;
  logic [DIGITS*4-1:0]   out;
  logic                  overflow;

  modport master (output start, in, input busy, done, out, overflow);
  modport slave  (input start, in, output busy, done, out, overflow);
endinterface

// File: rtl/oit_bin_to_bcd.sv
// Sequential double-dabble: one binary bit per clock, done pulses WIDTH+1 cycles after start is accepted.
// No backpressure: start is sampled only while idle, and is dropped without queuing while busy.
module oit_bin_to_bcd #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic             clock,
  input  logic             reset_n,
  oit_bin_to_bcd_if.slave  bus
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int BW = DIGITS * 4;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t          state;
  logic [WIDTH-1:0] shift_q;
  logic [BW-1:0]    bcd_q;
  logic             ovf_q;
  logic [CW-1:0]    cnt_q;
  logic             busy_q;
  logic             done_q;
  logic [BW-1:0]    out_q;
  logic             overflow_q;

  logic [BW-1:0]    bcd_adj;
  logic [BW-1:0]    bcd_next;
  logic [WIDTH-1:0] shift_next;
  logic             ovf_next;

  // Digits are adjusted independently; a digit >=5 becomes >=8 so its doubling carries out.
  always_comb begin
    bcd_adj = bcd_q;
    for (int d = 0; d < DIGITS; d++) begin
      if (bcd_q[d*4 +: 4] >= 4'd5) begin
        bcd_adj[d*4 +: 4] = bcd_q[d*4 +: 4] + 4'd3;
      end
    end
    bcd_next   = {bcd_adj[BW-2:0], shift_q[WIDTH-1]};
    shift_next = shift_q << 1;
    ovf_next   = ovf_q | bcd_adj[BW-1];
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      shift_q    <= '0;
      bcd_q      <= '0;
      ovf_q      <= 1'b0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      out_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            shift_q <= bus.in;
            bcd_q   <= '0;
            ovf_q   <= 1'b0;
            cnt_q   <= CW'(WIDTH);
            busy_q  <= 1'b1;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          bcd_q   <= bcd_next;
          shift_q <= shift_next;
          ovf_q   <= ovf_next;
          cnt_q   <= cnt_q - CW'(1);
          // Last shift: publish the post-shift value directly, not the stale working register.
          if (cnt_q == CW'(1)) begin
            out_q      <= bcd_next;
            overflow_q <= ovf_next;
            done_q     <= 1'b1;
            busy_q     <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.out      = out_q;
  assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_oit_bin_to_bcd.sv
// Scoreboard bench: stimulus pushes expected results, a negedge monitor pops them on each done pulse.
module tb_oit_bin_to_bcd;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  oit_bin_to_bcd_if #(.WIDTH(16), .DIGITS(5)) bus5 ();
  oit_bin_to_bcd_if #(.WIDTH(16), .DIGITS(4)) bus4 ();

  oit_bin_to_bcd #(.WIDTH(16), .DIGITS(5)) u_dut5 (.clock(clock), .reset_n(reset_n), .bus(bus5));
  oit_bin_to_bcd #(.WIDTH(16), .DIGITS(4)) u_dut4 (.clock(clock), .reset_n(reset_n), .bus(bus4));

  typedef struct {
    logic [19:0] out;
    logic        ovf;
    int          due;
  } exp_t;

  exp_t        q5[$];
  exp_t        q4[$];
  exp_t        e5;
  exp_t        e4;
  int          bc5 = 0;
  int          bc4 = 0;
  logic [19:0] held5 = '0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Monitor: compares only when a DUT presents done; also checks busy length and result hold.
  always @(negedge clock) begin
    if (!reset_n) begin
      bc5 = 0;
      bc4 = 0;
    end else begin
      if (bus5.done) begin
        if (q5.size() == 0) begin
          chk("unexp_done5", 32'(bus5.done), 32'd0);
        end else begin
          e5 = q5.pop_front();
          chk("out5", 32'(bus5.out), 32'(e5.out));
          chk("ovf5", 32'(bus5.overflow), 32'(e5.ovf));
          chk("lat5", 32'(cyc), 32'(e5.due));
          chk("busylen5", 32'(bc5), 32'd16);
          held5 = e5.out;
        end
        bc5 = 0;
      end else if (bus5.busy) begin
        bc5++;
        chk("hold5", 32'(bus5.out), 32'(held5));
      end
      if (bus4.done) begin
        if (q4.size() == 0) begin
          chk("unexp_done4", 32'(bus4.done), 32'd0);
        end else begin
          e4 = q4.pop_front();
          chk("out4", 32'(bus4.out), 32'(e4.out));
          chk("ovf4", 32'(bus4.overflow), 32'(e4.ovf));
          chk("lat4", 32'(cyc), 32'(e4.due));
          chk("busylen4", 32'(bc4), 32'd16);
        end
        bc4 = 0;
      end else if (bus4.busy) begin
        bc4++;
      end
    end
  end

  // Called at a negedge: drives start for one cycle, then scrambles in to prove it was captured.
  task automatic issue(input bit four, input logic [15:0] v, input logic [19:0] eout,
                       input logic eovf, input bit expect_it);
    exp_t e;
    e.out = eout;
    e.ovf = eovf;
    e.due = cyc + 17;
    if (four) begin
      bus4.start = 1'b1;
      bus4.in    = v;
      if (expect_it) q4.push_back(e);
    end else begin
      bus5.start = 1'b1;
      bus5.in    = v;
      if (expect_it) q5.push_back(e);
    end
    @(negedge clock);
    bus5.start = 1'b0;
    bus4.start = 1'b0;
    bus5.in    = 16'hA5A5;
    bus4.in    = 16'h5A5A;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((q5.size() != 0 || q4.size() != 0 || bus5.busy || bus4.busy) && n < 60) begin
      @(negedge clock);
      n++;
    end
    chk("drain", 32'(q5.size() + q4.size()), 32'd0);
    @(negedge clock);
  endtask

  task automatic wait_done5(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (bus5.done) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    bit seen;
    bus5.start = 1'b0; bus5.in = '0;
    bus4.start = 1'b0; bus4.in = '0;
    repeat (3) @(negedge clock);
    chk("rst_busy5", 32'(bus5.busy), 32'd0);
    chk("rst_done5", 32'(bus5.done), 32'd0);
    chk("rst_out5", 32'(bus5.out), 32'd0);
    chk("rst_ovf5", 32'(bus5.overflow), 32'd0);
    chk("rst_out4", 32'(bus4.out), 32'd0);
    reset_n = 1'b1;
    @(negedge clock);

    issue(0, 16'h0000, 20'h00000, 1'b0, 1'b1);
    wait_idle();
    issue(0, 16'hFFFF, 20'h65535, 1'b0, 1'b1);
    wait_idle();
    issue(0, 16'd10000, 20'h10000, 1'b0, 1'b1);
    wait_idle();

    // Back-to-back: second start lands in the done cycle of the first.
    issue(0, 16'd1234, 20'h01234, 1'b0, 1'b1);
    wait_done5(seen);
    chk("b2b_seen", 32'(seen), 32'd1);
    issue(0, 16'd9999, 20'h09999, 1'b0, 1'b1);
    wait_idle();

    issue(1, 16'd10000, 20'h00000, 1'b1, 1'b1);
    wait_idle();
    issue(1, 16'd9999, 20'h09999, 1'b0, 1'b1);
    wait_idle();

    // Start pulsed while busy must be ignored.
    issue(0, 16'd4321, 20'h04321, 1'b0, 1'b1);
    repeat (4) @(negedge clock);
    issue(0, 16'd1, 20'h00000, 1'b0, 1'b0);
    wait_idle();

    // Reset mid-run: abandoned, no done, result cleared.
    issue(0, 16'd500, 20'h00500, 1'b0, 1'b0);
    repeat (7) @(negedge clock);
    reset_n = 1'b0;
    held5   = '0;
    @(negedge clock);
    reset_n = 1'b1;
    chk("abort_busy", 32'(bus5.busy), 32'd0);
    chk("abort_done", 32'(bus5.done), 32'd0);
    chk("abort_out", 32'(bus5.out), 32'd0);
    repeat (20) @(negedge clock);
    chk("abort_quiet", 32'(bus5.out), 32'd0);
    issue(0, 16'd42, 20'h00042, 1'b0, 1'b1);
    wait_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
